// File: rtl/multi_cycle_control_fsm.sv
// Sequencing controller for the multi-cycle CPU: Moore FSM stepping IF/ID/EXE/MEM/WB plus opcode decode.
// Optional feature macro HALT_CTRL_EN: the halt opcode parks the FSM in HALT until Reset.
module multi_cycle_control_fsm #(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [OP_W-1:0]  op,
    input  logic             zero,
    input  logic             sign,
    output logic [2:0]       state,
    output logic             PCWre,
    output logic             IRWre,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic             DBDataSrc,
    output logic             RegWre,
    output logic             WrRegDSrc,
    output logic             mRD,
    output logic             mWR,
    output logic [1:0]       RegDst,
    output logic             ExtSel,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUOp,
    output logic [CNT_W-1:0] InsCount
);
    localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OP_W-1:0] OP_AND   = 6'b010000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b010011;
    localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b100110;
    localparam logic [OP_W-1:0] OP_SLT   = 6'b100111;
    localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
    localparam logic [OP_W-1:0] OP_BLTZ  = 6'b110110;
    localparam logic [OP_W-1:0] OP_J     = 6'b111000;
    localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    state_t     cur;
    logic       halted;
    logic       haltReq;
    logic       isAlu, isBranch, isLs, isJump, isJal, isJr, isLw, isSw, brTaken;
    logic       decSrcA, decSrcB, decZeroExt;
    logic [1:0] decRegDst;
    logic [2:0] decAluOp;

`ifdef HALT_CTRL_EN
    localparam logic [OP_W-1:0] OP_HALT = 6'b111111;
    assign haltReq = (op == OP_HALT);
`else
    assign haltReq = 1'b0;
    assign halted  = 1'b0;
`endif

    // HALT shares encoding 111 with WB_AL; the halted flag disambiguates.
    assign state = halted ? 3'b111 : cur;

    always_comb begin
        isAlu = 1'b0; isBranch = 1'b0; isLs = 1'b0; isJump = 1'b0;
        isJal = 1'b0; isJr = 1'b0; isLw = 1'b0; isSw = 1'b0; brTaken = 1'b0;
        decSrcA = 1'b0; decSrcB = 1'b0; decZeroExt = 1'b0;
        decRegDst = 2'b00; decAluOp = 3'b000;
        case (op)
            OP_ADD:   begin isAlu = 1'b1; decRegDst = 2'b10; end
            OP_SUB:   begin isAlu = 1'b1; decRegDst = 2'b10; decAluOp = 3'b001; end
            OP_ADDIU: begin isAlu = 1'b1; decRegDst = 2'b01; decSrcB = 1'b1; end
            OP_AND:   begin isAlu = 1'b1; decRegDst = 2'b10; decAluOp = 3'b100; end
            OP_ANDI:  begin isAlu = 1'b1; decRegDst = 2'b01; decSrcB = 1'b1; decZeroExt = 1'b1; decAluOp = 3'b100; end
            OP_ORI:   begin isAlu = 1'b1; decRegDst = 2'b01; decSrcB = 1'b1; decZeroExt = 1'b1; decAluOp = 3'b011; end
            OP_XORI:  begin isAlu = 1'b1; decRegDst = 2'b01; decSrcB = 1'b1; decZeroExt = 1'b1; decAluOp = 3'b111; end
            OP_SLL:   begin isAlu = 1'b1; decRegDst = 2'b10; decSrcA = 1'b1; decAluOp = 3'b010; end
            OP_SLTI:  begin isAlu = 1'b1; decRegDst = 2'b01; decSrcB = 1'b1; decAluOp = 3'b110; end
            OP_SLT:   begin isAlu = 1'b1; decRegDst = 2'b10; decAluOp = 3'b110; end
            OP_SW:    begin isLs = 1'b1; isSw = 1'b1; decSrcB = 1'b1; end
            OP_LW:    begin isLs = 1'b1; isLw = 1'b1; decSrcB = 1'b1; decRegDst = 2'b01; end
            OP_BEQ:   begin isBranch = 1'b1; decAluOp = 3'b001; brTaken = zero; end
            OP_BNE:   begin isBranch = 1'b1; decAluOp = 3'b001; brTaken = ~zero; end
            OP_BLTZ:  begin isBranch = 1'b1; brTaken = sign; end
            OP_J:     isJump = 1'b1;
            OP_JR:    begin isJump = 1'b1; isJr = 1'b1; end
            OP_JAL:   begin isJump = 1'b1; isJal = 1'b1; end
            default:  ;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cur      <= S_IF;
            InsCount <= '0;
`ifdef HALT_CTRL_EN
            halted   <= 1'b0;
`endif
        end else begin
            if (PCWre) InsCount <= InsCount + CNT_W'(1);
            if (!halted) begin
                case (cur)
                    S_IF:     cur <= S_ID;
                    S_ID: begin
                        if (isBranch)      cur <= S_EXE_BR;
                        else if (isLs)     cur <= S_EXE_LS;
                        else if (isAlu)    cur <= S_EXE_AL;
                        else if (!haltReq) cur <= S_IF;
`ifdef HALT_CTRL_EN
                        if (haltReq) halted <= 1'b1;
`endif
                    end
                    S_EXE_AL: cur <= S_WB_AL;
                    S_EXE_LS: cur <= S_MEM;
                    S_MEM:    cur <= isLw ? S_WB_LD : S_IF;
                    default:  cur <= S_IF;
                endcase
            end
        end
    end

    always_comb begin
        PCWre = 1'b0; IRWre = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 1'b0;
        DBDataSrc = 1'b0; RegWre = 1'b0; WrRegDSrc = 1'b0; mRD = 1'b0; mWR = 1'b0;
        RegDst = 2'b00; ExtSel = 1'b0; PCSrc = 2'b00; ALUOp = 3'b000;
        // Decode fields only reflect the instruction once IR holds it (after IF).
        if (!halted && cur != S_IF) begin
            ALUSrcA   = decSrcA;
            ALUSrcB   = decSrcB;
            ExtSel    = ~decZeroExt;
            ALUOp     = decAluOp;
            RegDst    = decRegDst;
            DBDataSrc = isLw;
        end
        if (!halted) begin
            case (cur)
                S_IF: IRWre = 1'b1;
                S_ID: begin
                    PCWre  = ~(isAlu | isBranch | isLs | haltReq);
                    RegWre = isJal;
                    if (isJr)        PCSrc = 2'b10;
                    else if (isJump) PCSrc = 2'b11;
                end
                S_EXE_BR: begin
                    PCWre = 1'b1;
                    PCSrc = brTaken ? 2'b01 : 2'b00;
                end
                S_MEM: begin
                    mRD   = isLw;
                    mWR   = isSw;
                    PCWre = isSw;
                end
                S_WB_AL, S_WB_LD: begin
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    PCWre     = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
